// File: rtl/jtdd_rom_pkg.sv
// Shared FSM type, SDRAM address width and beat counts for the gfx ROM responder.
package jtdd_rom_pkg;

  localparam int SDRAM_AW = 22;
  localparam int BEATS_8  = 1;
  localparam int BEATS_16 = 1;
  localparam int BEATS_32 = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } rom_state_t;

  function automatic int rom_beats(input int dw);
    if (dw == 32) return BEATS_32;
    if (dw == 8) return BEATS_8;
    return BEATS_16;
  endfunction

endpackage

// File: rtl/jtdd_romrsp_cache.sv
// Tag/valid/data store (1 or 2 entries, LRU victim when 2); combinational lookup, fill written on the clock.
// No backpressure: a fill is always accepted and replaces an invalid entry first, else the LRU one.
module jtdd_romrsp_cache #(
  parameter int DEPTH = 1,
  parameter int TW    = 22,
  parameter int EW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] lookup_tag,
  input  logic          lookup_en,
  output logic          hit,
  output logic [EW-1:0] hit_dat,
  input  logic          fill_vld,
  input  logic [TW-1:0] fill_tag,
  input  logic [EW-1:0] fill_dat
);

  logic [DEPTH-1:0] valid;
  logic [TW-1:0]    tag [DEPTH];
  logic [EW-1:0]    dat [DEPTH];
  logic             lru;
  logic             hit_way;
  logic             victim;

  always_comb begin
    hit     = 1'b0;
    hit_dat = '0;
    hit_way = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag[i] == lookup_tag) begin
        hit     = 1'b1;
        hit_dat = dat[i];
        hit_way = 1'(i);
      end
    end
  end

  // Empty slots are used before evicting anything.
  always_comb begin
    victim = lru;
    if (DEPTH == 1) victim = 1'b0;
    else if (!valid[0]) victim = 1'b0;
    else if (!valid[DEPTH-1]) victim = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      lru   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tag[i] <= '0;
        dat[i] <= '0;
      end
    end else begin
      if (fill_vld) begin
        valid[victim] <= 1'b1;
        tag[victim]   <= fill_tag;
        dat[victim]   <= fill_dat;
        lru           <= ~victim;
      end else if (lookup_en && hit) begin
        lru <= ~hit_way;
      end
    end
  end

endmodule

// File: rtl/jtdd_romrsp.sv
// Gfx ROM responder: maps requester addr to SDRAM words, fetches on miss, ok one clk after a hit.
// SDRAM req held until ack; optional 2-entry LRU cache with JTDD_ROMRSP_CACHE_EN, else one entry.
module jtdd_romrsp
  import jtdd_rom_pkg::*;
#(
  parameter int                  AW     = 17,
  parameter int                  DW     = 16,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  output logic [DW-1:0]       dout,
  output logic                ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                sdram_dst,
  input  logic [15:0]         sdram_din
);

  localparam int EW     = (DW == 32) ? 32 : 16;
  localparam int NBEATS = rom_beats(DW);
`ifdef JTDD_ROMRSP_CACHE_EN
  localparam int DEPTH  = 2;
`else
  localparam int DEPTH  = 1;
`endif

  rom_state_t          state, state_nxt;
  logic [SDRAM_AW-1:0] word_ofs, cur_word, addr_nxt;
  logic                req_nxt;
  logic                beat, beat_nxt, beat_ok;
  logic                fill_vld, hit, bypass;
  logic [EW-1:0]       hit_dat, fill_dat, word_dat;
  logic [DW-1:0]       sel_dat;

  if (DW == 8) begin : g_map8
    assign word_ofs = SDRAM_AW'(addr[AW-1:1]);
  end else if (DW == 32) begin : g_map32
    assign word_ofs = SDRAM_AW'({addr, 1'b0});
  end else begin : g_map16
    assign word_ofs = SDRAM_AW'(addr);
  end

  // Wraps modulo 2^22 by construction of the result width.
  assign cur_word = OFFSET + word_ofs;

  if (EW == 32) begin : g_fill32
    logic [15:0] beat_lo;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat_lo <= '0;
      else if (beat_ok) beat_lo <= sdram_din;
    end
    assign fill_dat = {sdram_din, beat_lo};
  end else begin : g_fill16
    assign fill_dat = sdram_din;
  end

  jtdd_romrsp_cache #(
    .DEPTH (DEPTH),
    .TW    (SDRAM_AW),
    .EW    (EW)
  ) u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (cur_word),
    .lookup_en  (cs),
    .hit        (hit),
    .hit_dat    (hit_dat),
    .fill_vld   (fill_vld),
    .fill_tag   (sdram_addr),
    .fill_dat   (fill_dat)
  );

  always_comb begin
    state_nxt = state;
    req_nxt   = sdram_req;
    addr_nxt  = sdram_addr;
    beat_nxt  = beat;
    fill_vld  = 1'b0;
    // A dst arriving alongside ack already belongs to this transfer.
    beat_ok   = sdram_dst && (state == WAIT || (state == REQ && sdram_ack));
    case (state)
      IDLE: begin
        if (cs && !hit) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
          addr_nxt  = cur_word;
          beat_nxt  = 1'b0;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          state_nxt = WAIT;
          req_nxt   = 1'b0;
        end
      end
      default: ;
    endcase
    if (beat_ok) begin
      if (NBEATS == 1 || beat) begin
        fill_vld  = 1'b1;
        state_nxt = IDLE;
      end else begin
        beat_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      beat       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
      beat       <= beat_nxt;
    end
  end

  // Forward the word being filled so ok rises the clk right after the last beat.
  assign bypass   = fill_vld && (sdram_addr == cur_word);
  assign word_dat = bypass ? fill_dat : hit_dat;

  if (DW == 8) begin : g_sel8
    assign sel_dat = addr[0] ? word_dat[15:8] : word_dat[7:0];
  end else begin : g_seln
    assign sel_dat = word_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok   <= 1'b0;
      dout <= '0;
    end else if (cs && (hit || bypass)) begin
      ok   <= 1'b1;
      dout <= sel_dat;
    end else begin
      ok   <= 1'b0;
    end
  end

endmodule
